nbr_mean_filter: RTL and testbench
==================================

Name: nbr_mean_filter

Overview:
- Pixel datapath driven by the BRAM control stage. Walks a source image held in BRAM port A and writes a filtered image to BRAM port B.
- Each interior output pixel is the mean of its 8 neighbours, fetched in neighbour order sel = 0..7. Border output pixels are written as 0.
- Asserts complete when the whole frame has been written. It is the consumer of the ena/enb/wea/sel control scheme, built as a self-sequencing stage.

Parameters:
- IMG_W, 256, image width in pixels (>= 3).
- IMG_H, 256, image height in pixels (>= 3).
- PIX_W, 8, bits per pixel.
- ADDR_W, 16, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one frame; sampled only in IDLE.
- ena  out  1  read enable, BRAM port A (source).
- addra  out  ADDR_W  read address, port A.
- douta  in  PIX_W  read data, port A; valid 1 cycle after ena.
- enb  out  1  enable, BRAM port B (destination).
- wea  out  1  write enable, port B.
- addrb  out  ADDR_W  write address, port B.
- dinb  out  PIX_W  write data, port B.
- sel  out  3  current neighbour index being fetched.
- busy  out  1  frame in progress.
- complete  out  1  frame done; level.

Behaviour:
- Reset, applied asynchronously at any time including mid-frame: state=IDLE; ena, enb, wea, busy, complete=0; addra, addrb, dinb, sel=0; accumulator=0; x=y=0.
- Addressing: addr = y*IMG_W + x, raster order, x fastest.
- Neighbour offsets by sel: 0=(-1,-1), 1=(0,-1), 2=(+1,-1), 3=(-1,0), 4=(+1,0), 5=(-1,+1), 6=(0,+1), 7=(+1,+1).
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: start=1 -> busy=1, complete=0, x=y=0. Go to WRITE if the pixel is a border pixel, else FETCH.
- FETCH: 8 cycles. Each cycle ena=1, addra = neighbour address for sel; sel increments 0..7.
  - Data returned from the previous cycle's read is added to a PIX_W+3 bit accumulator. The accumulator is cleared on entry.
  - After sel=7 go to DRAIN.
- DRAIN: 1 cycle. ena=0; adds the 8th read datum.
- WRITE: 1 cycle. enb=1, wea=1, addrb = centre address.
  - dinb = accumulator[PIX_W+2:3] for interior pixels (truncating divide by 8; no overflow possible). dinb = 0 for border pixels.
  - Then advance x/y. Last pixel -> DONE; next pixel border -> WRITE; next pixel interior -> FETCH.
- Border pixel: x==0, x==IMG_W-1, y==0 or y==IMG_H-1. No reads are issued for border pixels.
- Cost per pixel: border 1 cycle; interior 10 cycles. Frame cycles = border_count + 10*(IMG_W-2)*(IMG_H-2).
- DONE: busy=0, complete=1 held. Go to IDLE in the same cycle so a new start is accepted. complete clears when the next start is accepted.
- ena, enb and wea are 0 in every state/cycle not listed above.
- sel: 0 outside FETCH; it never wraps within a pixel.
- start while busy is ignored. start held continuously re-triggers a frame one cycle after DONE.
- Wrap-around:
  - x wraps from IMG_W-1 to 0 with y+1.
  - The last pixel (IMG_W-1, IMG_H-1) terminates the frame.
  - The address counter never exceeds IMG_W*IMG_H-1.

Decomposition:
- Shared package nbr_filter_pkg:
  - state enum (IDLE, FETCH, DRAIN, WRITE, DONE);
  - neighbour dx/dy constant table indexed by sel;
  - accumulator width constant PIX_W+3.
- One natural combinational sub-module, nbr_addr_gen. Inputs: x, y, sel. Output: the neighbour address. It is the only place the offset table is applied.

Test Plan:
- IMG_W=IMG_H=4, all source pixels 100, pulse start -> busy high exactly 52 cycles (12 border + 4x10); dest interior (5,6,9,10) = 100, all 12 border = 0; complete=1 after.
- Same image, source pixel = address (0..15) -> dest[5] = (0+1+2+4+6+8+9+10)>>3 = 5; dest[6] = 48>>3 = 6.
- All source pixels 255 -> interior dest = 255 (sum 2040, no overflow).
- During FETCH of pixel 5, check read address sequence: addra = 0,1,2,4,6,8,9,10 with sel = 0..7 on consecutive cycles, then one ena=0 cycle, then wea=1 with addrb=5.
- Assert rst_n=0 mid-FETCH -> outputs 0 immediately without a clock edge; restart with start -> frame completes correctly from pixel 0.
- Pulse start while busy -> ignored, frame length unchanged; start held high -> second frame begins the cycle after complete rises, and complete drops when it is accepted.

Source files
------------

// File: rtl/nbr_filter_pkg.sv
// Shared definitions for the neighbour-mean filter: FSM states, the
// neighbour offset table and accumulator sizing.
package nbr_filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // Eight PIX_W-bit samples sum without overflow in PIX_W+3 bits.
  localparam int ACC_GUARD = 3;

  // Neighbour offsets indexed by sel: top row, middle row (left, right), bottom row.
  localparam int NBR_DX [8] = '{-1,  0,  1, -1,  1, -1,  0,  1};
  localparam int NBR_DY [8] = '{-1, -1, -1,  0,  0,  1,  1,  1};

  function automatic int acc_width(input int pix_w);
    return pix_w + ACC_GUARD;
  endfunction

  function automatic logic is_border(input int x, input int y, input int w, input int h);
    return (x == 0) || (x == w - 1) || (y == 0) || (y == h - 1);
  endfunction

endpackage

// File: rtl/nbr_addr_gen.sv
// Combinational neighbour address: (y+dy)*IMG_W + (x+dx) for the selected neighbour.
module nbr_addr_gen
  import nbr_filter_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int ADDR_W = 16,
  parameter int XW     = 8,
  parameter int YW     = 8
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [2:0]        sel,
  output logic [ADDR_W-1:0] addr
);

  int nbr_x;
  int nbr_y;

  always_comb begin
    nbr_x = int'(x) + NBR_DX[sel];
    nbr_y = int'(y) + NBR_DY[sel];
    addr  = ADDR_W'(nbr_y * IMG_W + nbr_x);
  end

endmodule

// File: rtl/nbr_mean_filter.sv
// Self-sequencing 8-neighbour mean filter: reads source pixels from BRAM port A,
// writes the filtered frame (zero border) to BRAM port B in raster order.
module nbr_mean_filter
  import nbr_filter_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  input  logic [PIX_W-1:0]  douta,
  output logic              enb,
  output logic              wea,
  output logic [ADDR_W-1:0] addrb,
  output logic [PIX_W-1:0]  dinb,
  output logic [2:0]        sel,
  output logic              busy,
  output logic              complete
);

  localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int ACC_W = acc_width(PIX_W);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [2:0]          sel_q, sel_d;
  logic                ena_q, ena_d;
  logic                enb_q, enb_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic [PIX_W-1:0]    dinb_q, dinb_d;
  logic                busy_q, busy_d;
  logic                complete_q, complete_d;

  logic [XW-1:0]       nxt_x;
  logic [YW-1:0]       nxt_y;
  logic                last_pix;
  logic [ACC_W-1:0]    acc_sum;

  logic [XW-1:0]       gen_x;
  logic [YW-1:0]       gen_y;
  logic [2:0]          gen_sel;
  logic [ADDR_W-1:0]   gen_addr;

  always_comb begin
    if (x_q == X_LAST) begin
      nxt_x = '0;
      nxt_y = y_q + YW'(1);
    end else begin
      nxt_x = x_q + XW'(1);
      nxt_y = y_q;
    end
    last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
    acc_sum  = acc_q + ACC_W'(douta);
  end

  // Address generator looks one step ahead so addra is registered with its sel.
  always_comb begin
    gen_x   = x_q;
    gen_y   = y_q;
    gen_sel = sel_q + 3'd1;
    if (state_q == WRITE) begin
      gen_x   = nxt_x;
      gen_y   = nxt_y;
      gen_sel = '0;
    end
  end

  nbr_addr_gen #(
    .IMG_W  (IMG_W),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_addr_gen (
    .x    (gen_x),
    .y    (gen_y),
    .sel  (gen_sel),
    .addr (gen_addr)
  );

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    pix_addr_d = pix_addr_q;
    acc_d      = acc_q;
    sel_d      = '0;
    ena_d      = 1'b0;
    enb_d      = 1'b0;
    wea_d      = 1'b0;
    addra_d    = '0;
    addrb_d    = '0;
    dinb_d     = '0;
    busy_d     = busy_q;
    complete_d = complete_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Pixel (0,0) is always a border pixel, so a frame opens with a write.
          busy_d     = 1'b1;
          complete_d = 1'b0;
          x_d        = '0;
          y_d        = '0;
          pix_addr_d = '0;
          state_d    = WRITE;
          enb_d      = 1'b1;
          wea_d      = 1'b1;
        end
      end

      FETCH: begin
        if (sel_q != 3'd0) begin
          acc_d = acc_sum;
        end
        if (sel_q == 3'd7) begin
          state_d = DRAIN;
        end else begin
          sel_d   = sel_q + 3'd1;
          ena_d   = 1'b1;
          addra_d = gen_addr;
        end
      end

      DRAIN: begin
        acc_d   = acc_sum;
        state_d = WRITE;
        enb_d   = 1'b1;
        wea_d   = 1'b1;
        addrb_d = pix_addr_q;
        dinb_d  = acc_sum[PIX_W+2:3];
      end

      WRITE: begin
        if (last_pix) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          complete_d = 1'b1;
          x_d        = '0;
          y_d        = '0;
          pix_addr_d = '0;
        end else begin
          x_d        = nxt_x;
          y_d        = nxt_y;
          pix_addr_d = pix_addr_q + ADDR_W'(1);
          if (is_border(int'(nxt_x), int'(nxt_y), IMG_W, IMG_H)) begin
            state_d = WRITE;
            enb_d   = 1'b1;
            wea_d   = 1'b1;
            addrb_d = pix_addr_q + ADDR_W'(1);
          end else begin
            state_d = FETCH;
            acc_d   = '0;
            ena_d   = 1'b1;
            addra_d = gen_addr;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      pix_addr_q <= '0;
      acc_q      <= '0;
      sel_q      <= '0;
      ena_q      <= 1'b0;
      enb_q      <= 1'b0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      addrb_q    <= '0;
      dinb_q     <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_addr_q <= pix_addr_d;
      acc_q      <= acc_d;
      sel_q      <= sel_d;
      ena_q      <= ena_d;
      enb_q      <= enb_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      addrb_q    <= addrb_d;
      dinb_q     <= dinb_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
    end
  end

  assign ena      = ena_q;
  assign addra    = addra_q;
  assign enb      = enb_q;
  assign wea      = wea_q;
  assign addrb    = addrb_q;
  assign dinb     = dinb_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_nbr_mean_filter.sv
// Scoreboard bench for nbr_mean_filter on a 4x4 image with a BRAM model on port A.
module tb_nbr_mean_filter;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;
  localparam int AW = 16;
  localparam int N  = W * H;
  localparam int FRAME_CYC = 52;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ena, enb, wea, busy, complete;
  logic [AW-1:0] addra, addrb;
  logic [PW-1:0] douta = '0;
  logic [PW-1:0] dinb;
  logic [2:0]    sel;

  nbr_mean_filter #(
    .IMG_W  (W),
    .IMG_H  (H),
    .PIX_W  (PW),
    .ADDR_W (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ena      (ena),
    .addra    (addra),
    .douta    (douta),
    .enb      (enb),
    .wea      (wea),
    .addrb    (addrb),
    .dinb     (dinb),
    .sel      (sel),
    .busy     (busy),
    .complete (complete)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] src [N];

  always @(posedge clk) begin
    if (ena) douta <= (int'(addra) < N) ? src[int'(addra)] : 8'hEE;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: every port-B write is matched against the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && enb && wea) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0d, want no write", addrb, dinb);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(addrb), 32'(e.addr));
        check("wr_data", 32'(dinb), 32'(e.data));
      end
    end
  end

  // Expected destination frame: zero border, hand-computed interior pixels 5, 6, 9, 10.
  task automatic push_frame(input logic [PW-1:0] c5, input logic [PW-1:0] c6,
                            input logic [PW-1:0] c9, input logic [PW-1:0] c10);
    for (int i = 0; i < N; i++) begin
      wr_t e;
      e.addr = AW'(i);
      case (i)
        5:       e.data = c5;
        6:       e.data = c6;
        9:       e.data = c9;
        10:      e.data = c10;
        default: e.data = '0;
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_const(input logic [PW-1:0] v);
    for (int i = 0; i < N; i++) src[i] = v;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) src[i] = PW'(i);
  endtask

  // Pulse start, then count busy cycles; optional extra start pulse at busy cycle glitch_at.
  task automatic run_frame(input int glitch_at, output int cycles);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    cycles = 0;
    while (busy && cycles < 500) begin
      start = (cycles == glitch_at);
      cycles++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_ena(input string name);
    int k;
    k = 0;
    while (!ena && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(ena), 32'd1);
  endtask

  int cyc;
  int seq [8] = '{0, 1, 2, 4, 6, 8, 9, 10};

  initial begin
    #12;
    check("reset_ctrl", 32'({ena, enb, wea, busy, complete}), 32'd0);
    check("reset_addra", 32'(addra), 32'd0);
    check("reset_addrb", 32'(addrb), 32'd0);
    check("reset_dinb", 32'(dinb), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    fill_const(8'd100);
    push_frame(8'd100, 8'd100, 8'd100, 8'd100);
    run_frame(-1, cyc);
    check("len_const100", 32'(cyc), 32'(FRAME_CYC));
    check("complete_const100", 32'(complete), 32'd1);
    check("drained_const100", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("complete_held", 32'({complete, busy}), 32'b10);

    fill_ramp();
    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    run_frame(-1, cyc);
    check("len_ramp", 32'(cyc), 32'(FRAME_CYC));
    check("drained_ramp", 32'(exp_q.size()), 32'd0);

    fill_const(8'd255);
    push_frame(8'd255, 8'd255, 8'd255, 8'd255);
    run_frame(-1, cyc);
    check("len_255", 32'(cyc), 32'(FRAME_CYC));
    check("drained_255", 32'(exp_q.size()), 32'd0);

    fill_ramp();
    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_ena("fetch_seen");
    for (int s = 0; s < 8; s++) begin
      check("seq_ena", 32'(ena), 32'd1);
      check("seq_sel", 32'(sel), 32'(s));
      check("seq_addra", 32'(addra), 32'(seq[s]));
      @(negedge clk);
    end
    check("drain_idle", 32'({ena, enb, wea}), 32'd0);
    @(negedge clk);
    check("seq_wea", 32'(wea), 32'd1);
    check("seq_addrb", 32'(addrb), 32'd5);
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    check("complete_seq", 32'(complete), 32'd1);
    check("drained_seq", 32'(exp_q.size()), 32'd0);

    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_ena("fetch_seen_rst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 32'({ena, enb, wea, busy, complete}), 32'd0);
    check("async_rst_addra", 32'(addra), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    push_frame(8'd5, 8'd6, 8'd9, 8'd10);
    run_frame(-1, cyc);
    check("len_after_rst", 32'(cyc), 32'(FRAME_CYC));
    check("drained_after_rst", 32'(exp_q.size()), 32'd0);

    fill_const(8'd100);
    push_frame(8'd100, 8'd100, 8'd100, 8'd100);
    run_frame(20, cyc);
    check("len_glitch", 32'(cyc), 32'(FRAME_CYC));
    @(negedge clk);
    check("no_retrigger", 32'(busy), 32'd0);
    check("drained_glitch", 32'(exp_q.size()), 32'd0);

    push_frame(8'd100, 8'd100, 8'd100, 8'd100);
    push_frame(8'd100, 8'd100, 8'd100, 8'd100);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    check("len_held1", 32'(cyc), 32'(FRAME_CYC));
    check("held_done", 32'({complete, busy}), 32'b10);
    @(negedge clk);
    check("held_restart", 32'({complete, busy}), 32'b01);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      @(negedge clk);
    end
    check("len_held2", 32'(cyc), 32'(FRAME_CYC));
    check("complete_held2", 32'(complete), 32'd1);
    check("drained_held", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
